csr_trap_ctrl: RTL and testbench
================================

// Module: csr_trap_ctrl
// PURPOSE
//  Machine-mode CSR file plus trap sequencer for the rv32i core. Sits beside the decoder in execute.
//  Executes CSRRW/S/C and their immediate forms in one cycle. Sequences ECALL, EBREAK, MRET and
//  illegal-CSR traps through a small FSM that stalls the pipeline and redirects the PC.
// PARAMETERS
//  XLEN        32          data width; only 32 is supported
//  MTVEC_RST   32'h0000_0000  reset value of mtvec
// PORTS
//  clk         in   1   single clock, all state on posedge
//  rst         in   1   synchronous reset, active-high
//  valid       in   1   instruction in execute is valid this cycle
//  op          in   7   opcode; SYSTEM = 7'b1110011
//  f3          in   3   funct3
//  f12         in   12  instr[31:20]: CSR address, or funct12 when f3 = 000
//  rs1_idx     in   5   instr[19:15]: rs1 index, or uimm for immediate forms
//  rs1_val     in   32  rs1 operand
//  pc          in   32  PC of the instruction in execute
//  retire      in   1   one instruction retires this cycle
//  csr_rdata   out  32  old CSR value, routed to rd (combinational)
//  reg_write   out  1   write csr_rdata to rd
//  stall       out  1   freeze fetch/decode/execute
//  pc_redirect out  1   load pc_target into the PC
//  pc_target   out  32  redirect address
// BEHAVIOUR
//  Reset: FSM=IDLE; mstatus=0; mepc=0; mcause=0; mscratch=0; mtvec=MTVEC_RST.
//   All outputs are 0 during and after reset until the next decode.
//  CSRs: mstatus 0x300 (only MIE[3] and MPIE[7] are writable; other bits read 0), mtvec 0x305
//   ([1:0] read 0), mscratch 0x340, mepc 0x341 ([1:0] forced 0), mcause 0x342.
//   Any other address is illegal.
//  CSR op (IDLE, valid, op=SYSTEM, f3 != 000):
//   - src = f3[2] ? {27'b0, rs1_idx} : rs1_val.
//   - Update rule: RW sets new=src; RS sets new=old|src; RC sets new=old&~src.
//   - The write commits at the next edge. RS/RC with rs1_idx=0 perform no write.
//   - reg_write=1 and csr_rdata=old value in the same cycle, with zero added latency.
//   - f3=100 (reserved) is illegal.
//  FSM states: IDLE, SAVE, VECTOR, RETURN.
//   - IDLE to SAVE on ECALL (f12=000, mcause=11), EBREAK (f12=001, mcause=3), or illegal
//     CSR/f3 (mcause=2). reg_write=0, and stall=1 in the decode cycle.
//   - SAVE edge: mepc<=pc (latched at decode), mcause<=code, MPIE<=MIE, MIE<=0. stall=1. Next state VECTOR.
//   - VECTOR: pc_redirect=1, pc_target={mtvec[31:2],2'b00}, stall=1. Next state IDLE.
//   - IDLE to RETURN on MRET (f3=000, f12=12'h302). stall=1 in the decode cycle.
//   - RETURN: pc_redirect=1, pc_target=mepc, MIE<=MPIE, MPIE<=1, stall=1. Next state IDLE.
//   - Any other f3=000 funct12 is illegal and traps with mcause=2.
//  Trap latency: decode cycle N, redirect in N+2 (N+1 for MRET), new fetch in N+3 (N+2).
//  Inputs with valid=1 while FSM != IDLE are ignored; the pipeline is held by stall.
//  A CSR write to mepc/mtvec in cycle N is visible to a trap decoded in N+1 (register bypass is not required).
//  rst mid-sequence: the FSM goes to IDLE at that edge; redirect is not issued; no CSR is updated.
//  Non-SYSTEM op or valid=0: reg_write=0 and no state change.
// CONFIGURATION
//  CSR_COUNTERS_EN defined:
//   - Adds mcycle (0xB00/0xB80) and minstret (0xB02/0xB82), each a 64-bit counter with lo/hi halves.
//   - Both reset to 0. mcycle increments every cycle. minstret increments when retire=1.
//   - A CSR write to a half in the same cycle wins over that cycle's increment; the carry into
//     the hi half uses the pre-write value.
//  CSR_COUNTERS_EN undefined: no counters; those addresses are illegal (mcause=2).
// STRUCTURE
//  csr_pkg: CSR address localparams, cause codes (2, 3, 11), FSM state encoding, f3 op codes.
//  Sub-module csr_regfile: storage, field masking, read mux, counters.
//   csr_trap_ctrl keeps the decode logic and FSM.
// TESTING
//  1. Reset, then CSRRW x1, mscratch with rs1=32'hDEAD_BEEF. Expect csr_rdata=0 and reg_write=1;
//     a following read returns DEAD_BEEF.
//  2. mscratch=32'hF0F0_F0F0, then CSRRCI with uimm=5'h10. Expect old F0F0_F0F0 on rd, new value F0F0_F0E0.
//     CSRRS with rs1_idx=0 performs no write.
//  3. mtvec=32'h0000_0103, mstatus.MIE=1, ECALL at pc=32'h0000_0040. Expect stall for N..N+2;
//     redirect to 32'h0000_0100 in N+2; mepc=40, mcause=11, MIE=0, MPIE=1.
//  4. MRET after test 3. Expect pc_target=32'h0000_0040 in N+1, MIE=1, MPIE=1.
//  5. CSRRW to 0x7C0, or reset asserted during SAVE. Expect mcause=2 and a trap for the first;
//     for the second, FSM in IDLE, no redirect, mepc unchanged.
//  6. With CSR_COUNTERS_EN, mcycle lo=32'hFFFF_FFFF. Expect the hi half to increment next cycle.
//     Without the macro, a read of 0xB00 traps with mcause=2.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file and trap sequencer.
//   - SYSTEM opcode, funct3 operation codes, funct12 values for ECALL/EBREAK/MRET
//   - CSR addresses (counter addresses are used only when CSR_COUNTERS_EN is defined)
//   - trap cause codes
//   - trap FSM state encoding
//   - csr_update(): the RW/RS/RC read-modify-write rule
package csr_pkg;

    localparam logic [6:0]  OP_SYSTEM      = 7'b1110011;

    localparam logic [2:0]  F3_PRIV        = 3'b000;
    localparam logic [2:0]  F3_CSRRW       = 3'b001;
    localparam logic [2:0]  F3_CSRRS       = 3'b010;
    localparam logic [2:0]  F3_CSRRC       = 3'b011;
    localparam logic [2:0]  F3_RSVD        = 3'b100;
    localparam logic [2:0]  F3_CSRRWI      = 3'b101;
    localparam logic [2:0]  F3_CSRRSI      = 3'b110;
    localparam logic [2:0]  F3_CSRRCI      = 3'b111;

    localparam logic [11:0] F12_ECALL      = 12'h000;
    localparam logic [11:0] F12_EBREAK     = 12'h001;
    localparam logic [11:0] F12_MRET       = 12'h302;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;

    localparam logic [31:0] CAUSE_ILLEGAL  = 32'd2;
    localparam logic [31:0] CAUSE_BREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_M  = 32'd11;

    localparam logic [1:0]  ST_IDLE        = 2'd0;
    localparam logic [1:0]  ST_SAVE        = 2'd1;
    localparam logic [1:0]  ST_VECTOR      = 2'd2;
    localparam logic [1:0]  ST_RETURN      = 2'd3;

    // kind is funct3[1:0]: 01 = write, 10 = set bits, 11 = clear bits.
    function automatic logic [31:0] csr_update(input logic [1:0]  kind,
                                               input logic [31:0] old_val,
                                               input logic [31:0] src);
        logic [31:0] res;
        case (kind)
            2'b01:   res = src;
            2'b10:   res = old_val | src;
            2'b11:   res = old_val & ~src;
            default: res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_regfile.sv
// csr_regfile: machine-mode CSR storage with field masking and the read mux.
//   Optional feature macro: CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   addr_i          CSR address for both read and write
//   wr_en_i         commit wr_data_i to addr_i at the next edge
//   wr_data_i       full 32-bit value to write (masked here per field)
//   save_i          trap entry: mepc/mcause load, MPIE<=MIE, MIE<=0
//   save_pc_i       PC of the trapping instruction
//   save_cause_i    trap cause code
//   restore_i       MRET: MIE<=MPIE, MPIE<=1
//   retire_i        instruction retired (minstret increment)
//   rdata_o         current value of addr_i
//   legal_o         addr_i names an implemented CSR
//   mtvec_o, mepc_o trap vector and return address
module csr_regfile
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] addr_i,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        save_i,
    input  logic [31:0] save_pc_i,
    input  logic [31:0] save_cause_i,
    input  logic        restore_i,
    input  logic        retire_i,
    output logic [31:0] rdata_o,
    output logic        legal_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    // Only the writable fields are stored; the rest read as zero.
    logic        mie_q;
    logic        mpie_q;
    logic [29:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [29:0] mepc_q;
    logic [31:0] mcause_q;

    assign mtvec_o = {mtvec_q, 2'b00};
    assign mepc_o  = {mepc_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST[31:2];
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (save_i) begin
            mepc_q   <= save_pc_i[31:2];
            mcause_q <= save_cause_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (restore_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (wr_en_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_q  <= wr_data_i[3];
                    mpie_q <= wr_data_i[7];
                end
                CSR_MTVEC:    mtvec_q    <= wr_data_i[31:2];
                CSR_MSCRATCH: mscratch_q <= wr_data_i;
                CSR_MEPC:     mepc_q     <= wr_data_i[31:2];
                CSR_MCAUSE:   mcause_q   <= wr_data_i;
                default: ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [63:0] mcycle_inc;
    logic [63:0] minstret_inc;

    // The increment is formed from the pre-write value, so a write to one half
    // replaces only that half and the other half still sees the old carry.
    assign mcycle_inc   = mcycle_q + 64'd1;
    assign minstret_inc = minstret_q + {63'd0, retire_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_inc;
            minstret_q <= minstret_inc;
            if (wr_en_i) begin
                case (addr_i)
                    CSR_MCYCLE:    mcycle_q[31:0]    <= wr_data_i;
                    CSR_MCYCLEH:   mcycle_q[63:32]   <= wr_data_i;
                    CSR_MINSTRET:  minstret_q[31:0]  <= wr_data_i;
                    CSR_MINSTRETH: minstret_q[63:32] <= wr_data_i;
                    default: ;
                endcase
            end
        end
    end
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    always_comb begin
        rdata_o = '0;
        legal_o = 1'b1;
        case (addr_i)
            CSR_MSTATUS:   rdata_o = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
            CSR_MTVEC:     rdata_o = {mtvec_q, 2'b00};
            CSR_MSCRATCH:  rdata_o = mscratch_q;
            CSR_MEPC:      rdata_o = {mepc_q, 2'b00};
            CSR_MCAUSE:    rdata_o = mcause_q;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    rdata_o = mcycle_q[31:0];
            CSR_MCYCLEH:   rdata_o = mcycle_q[63:32];
            CSR_MINSTRET:  rdata_o = minstret_q[31:0];
            CSR_MINSTRETH: rdata_o = minstret_q[63:32];
`endif
            default:       legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode CSR access and trap sequencing for the rv32i execute stage.
//   CSRRW/S/C and immediate forms complete in one cycle; ECALL, EBREAK, illegal
//   CSR accesses and MRET run through a four-state FSM that stalls and redirects.
//   Optional feature macro: CSR_COUNTERS_EN (mcycle/minstret, see csr_regfile).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   valid        instruction in execute is valid
//   op, f3, f12  opcode, funct3, instr[31:20] (CSR address or funct12)
//   rs1_idx      rs1 index / 5-bit immediate
//   rs1_val      rs1 operand
//   pc           PC of the instruction in execute
//   retire       one instruction retires this cycle
//   csr_rdata    old CSR value for rd (combinational)
//   reg_write    write csr_rdata to rd
//   stall        hold fetch/decode/execute
//   pc_redirect  load pc_target into the PC
//   pc_target    redirect address
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid,
    input  logic [6:0]      op,
    input  logic [2:0]      f3,
    input  logic [11:0]     f12,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] pc,
    input  logic            retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            reg_write,
    output logic            stall,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_target
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pend_pc_q, pend_cause_q;
    logic        csr_op, csr_we, do_trap, do_mret;
    logic [31:0] cause_d;
    logic [31:0] csr_old, csr_src, csr_new;
    logic        csr_legal;
    logic [31:0] mtvec_val, mepc_val;

    // Instruction decode; only acts while the sequencer is idle.
    always_comb begin
        csr_op  = 1'b0;
        do_trap = 1'b0;
        do_mret = 1'b0;
        cause_d = CAUSE_ILLEGAL;
        if (state_q == ST_IDLE && valid && op == OP_SYSTEM) begin
            if (f3 == F3_PRIV) begin
                case (f12)
                    F12_ECALL: begin
                        do_trap = 1'b1;
                        cause_d = CAUSE_ECALL_M;
                    end
                    F12_EBREAK: begin
                        do_trap = 1'b1;
                        cause_d = CAUSE_BREAK;
                    end
                    F12_MRET: do_mret = 1'b1;
                    default:  do_trap = 1'b1;
                endcase
            end else if (f3 == F3_RSVD || !csr_legal) begin
                do_trap = 1'b1;
            end else begin
                csr_op = 1'b1;
            end
        end
    end

    assign csr_src = f3[2] ? {27'd0, rs1_idx} : rs1_val;
    assign csr_new = csr_update(f3[1:0], csr_old, csr_src);
    // Set/clear with x0 / zero immediate is a pure read.
    assign csr_we  = csr_op && (f3[1:0] == 2'b01 || rs1_idx != 5'd0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (do_trap)      state_d = ST_SAVE;
                else if (do_mret) state_d = ST_RETURN;
            end
            ST_SAVE:   state_d = ST_VECTOR;
            ST_VECTOR: state_d = ST_IDLE;
            ST_RETURN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // PC and cause are captured at decode and committed on the SAVE edge,
    // so a reset during SAVE leaves mepc/mcause untouched.
    always_ff @(posedge clk) begin
        if (do_trap) begin
            pend_pc_q    <= pc;
            pend_cause_q <= cause_d;
        end
    end

    csr_regfile #(
        .MTVEC_RST (MTVEC_RST)
    ) u_regfile (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (f12),
        .wr_en_i      (csr_we),
        .wr_data_i    (csr_new),
        .save_i       (state_q == ST_SAVE),
        .save_pc_i    (pend_pc_q),
        .save_cause_i (pend_cause_q),
        .restore_i    (state_q == ST_RETURN),
        .retire_i     (retire),
        .rdata_o      (csr_old),
        .legal_o      (csr_legal),
        .mtvec_o      (mtvec_val),
        .mepc_o       (mepc_val)
    );

    assign reg_write   = !rst && csr_op;
    assign csr_rdata   = reg_write ? csr_old : '0;
    assign stall       = !rst && (do_trap || do_mret || state_q != ST_IDLE);
    assign pc_redirect = !rst && (state_q == ST_VECTOR || state_q == ST_RETURN);
    assign pc_target   = !pc_redirect           ? '0 :
                         (state_q == ST_VECTOR) ? {mtvec_val[31:2], 2'b00} : mepc_val;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

    localparam logic [6:0] SYS = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  f3 = '0;
    logic [11:0] f12 = '0;
    logic [4:0]  rs1_idx = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] pc = '0;
    logic        retire = 1'b0;
    logic [31:0] csr_rdata;
    logic        reg_write;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] pc_target;

    int n_vec = 0;
    int n_bad = 0;

    // Reference machine state, kept as architectural fields.
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;

    always #5 clk = ~clk;

    csr_trap_ctrl #(
        .XLEN      (32),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .op          (op),
        .f3          (f3),
        .f12         (f12),
        .rs1_idx     (rs1_idx),
        .rs1_val     (rs1_val),
        .pc          (pc),
        .retire      (retire),
        .csr_rdata   (csr_rdata),
        .reg_write   (reg_write),
        .stall       (stall),
        .pc_redirect (pc_redirect),
        .pc_target   (pc_target)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic bit m_legal(input logic [11:0] a);
        case (a)
            12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hB80, 12'hB02, 12'hB82:          return 1'b1;
`endif
            default:                                     return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [11:0] a, input logic [31:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h305: m_mtvec    = v & 32'hFFFF_FFFC;
            12'h340: m_mscratch = v;
            12'h341: m_mepc     = v & 32'hFFFF_FFFC;
            12'h342: m_mcause   = v;
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = 32'h0; m_mscratch = 32'h0; m_mepc = 32'h0; m_mcause = 32'h0;
    endtask

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f,
                         input logic [11:0] c, input logic [4:0] i,
                         input logic [31:0] val, input logic [31:0] p);
        @(negedge clk);
        valid = v; op = o; f3 = f; f12 = c; rs1_idx = i; rs1_val = val; pc = p;
        retire = 1'($urandom);
        #1;
    endtask

    // Inputs presented while the sequencer is busy; they must be ignored.
    task automatic drive_junk();
        drive(1'($urandom), SYS, 3'($urandom), 12'($urandom), 5'($urandom), $urandom, $urandom);
    endtask

    task automatic expect_outs(input string tag, input bit rw, input logic [31:0] rd,
                               input bit st, input bit redir, input logic [31:0] tgt);
        check_val({tag, ".reg_write"},   {31'd0, reg_write},   {31'd0, rw});
        check_val({tag, ".csr_rdata"},   csr_rdata,            rd);
        check_val({tag, ".stall"},       {31'd0, stall},       {31'd0, st});
        check_val({tag, ".pc_redirect"}, {31'd0, pc_redirect}, {31'd0, redir});
        check_val({tag, ".pc_target"},   pc_target,            tgt);
    endtask

    // Called with the decode cycle already driven.
    task automatic trap_seq(input logic [31:0] code, input logic [31:0] p);
        expect_outs("trap.decode", 0, 0, 1, 0, 0);
        drive_junk();
        expect_outs("trap.save", 0, 0, 1, 0, 0);
        drive_junk();
        expect_outs("trap.vector", 0, 0, 1, 1, m_mtvec & 32'hFFFF_FFFC);
        m_mepc = p & 32'hFFFF_FFFC;
        m_mcause = code;
        m_mpie = m_mie;
        m_mie = 1'b0;
    endtask

    task automatic mret_seq();
        expect_outs("mret.decode", 0, 0, 1, 0, 0);
        drive_junk();
        expect_outs("mret.return", 0, 0, 1, 1, m_mepc);
        m_mie = m_mpie;
        m_mpie = 1'b1;
    endtask

    task automatic exec(input logic v, input logic [6:0] o, input logic [2:0] f,
                        input logic [11:0] c, input logic [4:0] i,
                        input logic [31:0] val, input logic [31:0] p);
        logic [31:0] old_v, src, nv;
        drive(v, o, f, c, i, val, p);
        if (!v || o != SYS) begin
            expect_outs("nop", 0, 0, 0, 0, 0);
        end else if (f == 3'b000) begin
            if (c == 12'h000)      trap_seq(32'd11, p);
            else if (c == 12'h001) trap_seq(32'd3, p);
            else if (c == 12'h302) mret_seq();
            else                   trap_seq(32'd2, p);
        end else if (f == 3'b100 || !m_legal(c)) begin
            trap_seq(32'd2, p);
        end else begin
            old_v = m_read(c);
            src = f[2] ? {27'd0, i} : val;
            expect_outs("csr", 1, old_v, 0, 0, 0);
            if (f[1:0] == 2'b01)  nv = src;
            else if (f[1:0] == 2'b10) nv = old_v | src;
            else                   nv = old_v & ~src;
            if (f[1:0] == 2'b01 || i != 5'd0) m_write(c, nv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b1; op = SYS; f3 = 3'b001; f12 = 12'h340;
        rs1_idx = 5'd1; rs1_val = 32'h1234_5678; pc = 32'h0;
        #1;
        expect_outs("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        m_reset();
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [11:0] raddr;
        logic [4:0]  ridx;
        int          r;
        logic [2:0]  csr_f3s [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        logic [11:0] legal_a [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

        m_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Basic write then read of mscratch.
        exec(1, SYS, 3'b001, 12'h340, 5'd1, 32'hDEAD_BEEF, 32'h0);
        exec(1, SYS, 3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'h0);

        // Clear-immediate, then set with x0 must not write.
        exec(1, SYS, 3'b001, 12'h340, 5'd2, 32'hF0F0_F0F0, 32'h0);
        exec(1, SYS, 3'b111, 12'h340, 5'h10, 32'h0, 32'h0);
        exec(1, SYS, 3'b010, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'h0);
        exec(1, SYS, 3'b010, 12'h340, 5'd0, 32'h0, 32'h0);

        // ECALL with MIE set and a misaligned mtvec, then readback and MRET.
        exec(1, SYS, 3'b001, 12'h305, 5'd3, 32'h0000_0103, 32'h0);
        exec(1, SYS, 3'b110, 12'h300, 5'd8, 32'h0, 32'h0);
        exec(1, SYS, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0000_0040);
        exec(1, SYS, 3'b010, 12'h341, 5'd0, 32'h0, 32'h0);
        exec(1, SYS, 3'b010, 12'h342, 5'd0, 32'h0, 32'h0);
        exec(1, SYS, 3'b010, 12'h300, 5'd0, 32'h0, 32'h0);
        exec(1, SYS, 3'b000, 12'h302, 5'd0, 32'h0, 32'h0000_0200);
        exec(1, SYS, 3'b010, 12'h300, 5'd0, 32'h0, 32'h0);

        // Illegal CSR address traps with cause 2.
        exec(1, SYS, 3'b001, 12'h7C0, 5'd1, 32'h5555_5555, 32'h0000_0080);
        exec(1, SYS, 3'b010, 12'h342, 5'd0, 32'h0, 32'h0);

        // Randomized instruction stream.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            ridx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if (r < 5)
                exec(0, SYS, 3'($urandom), 12'($urandom), ridx, $urandom, $urandom);
            else if (r < 10)
                exec(1, 7'($urandom_range(0, 114)), 3'($urandom), 12'($urandom), ridx, $urandom, $urandom);
            else if (r < 16)
                exec(1, SYS, 3'b000, 12'h000, 5'd0, 32'h0, $urandom);
            else if (r < 20)
                exec(1, SYS, 3'b000, 12'h001, 5'd0, 32'h0, $urandom);
            else if (r < 26)
                exec(1, SYS, 3'b000, 12'h302, 5'd0, 32'h0, $urandom);
            else if (r < 30)
                exec(1, SYS, 3'b000, 12'($urandom), ridx, $urandom, $urandom);
            else if (r < 34)
                exec(1, SYS, 3'b100, legal_a[$urandom_range(0, 4)], ridx, $urandom, $urandom);
            else begin
                rf3 = csr_f3s[$urandom_range(0, 5)];
                raddr = ($urandom_range(0, 99) < 85) ? legal_a[$urandom_range(0, 4)] : 12'($urandom);
`ifdef CSR_COUNTERS_EN
                if (raddr == 12'hB00 || raddr == 12'hB80 || raddr == 12'hB02 || raddr == 12'hB82)
                    raddr = 12'h340;
`endif
                exec(1, SYS, rf3, raddr, ridx, $urandom, $urandom);
            end
        end

        // Reset while in SAVE: no redirect and no trap state recorded.
        do_reset();
        drive(1, SYS, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0000_0080);
        expect_outs("rstsave.decode", 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_outs("rstsave.inreset", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        #1;
        expect_outs("rstsave.after", 0, 0, 0, 0, 0);
        m_reset();
        exec(1, SYS, 3'b010, 12'h341, 5'd0, 32'h0, 32'h0);
        exec(1, SYS, 3'b010, 12'h342, 5'd0, 32'h0, 32'h0);

`ifdef CSR_COUNTERS_EN
        // Low half of mcycle set to all-ones carries into the high half.
        drive(1, SYS, 3'b001, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'h0);
        check_val("mcycle.wr.reg_write", {31'd0, reg_write}, 32'd1);
        drive(1, SYS, 3'b010, 12'hB80, 5'd0, 32'h0, 32'h0);
        check_val("mcycleh.before", csr_rdata, 32'h0);
        drive(1, SYS, 3'b010, 12'hB80, 5'd0, 32'h0, 32'h0);
        check_val("mcycleh.after", csr_rdata, 32'h1);
        drive(1, SYS, 3'b010, 12'hB00, 5'd0, 32'h0, 32'h0);
        check_val("mcycle.lo.wrapped", csr_rdata, 32'h1);
`else
        // A read of mcycle traps as illegal, then mcause reads back 2.
        exec(1, SYS, 3'b010, 12'hB00, 5'd0, 32'h0, 32'h0000_0100);
        exec(1, SYS, 3'b010, 12'h342, 5'd0, 32'h0, 32'h0);
`endif

        @(negedge clk);
        valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
